// File: rtl/secded_stream_decoder.sv
// secded_stream_decoder: two-stage pipelined SECDED (extended Hamming) decoder
// with valid/ready handshakes on both sides.
//
// Codeword layout: bit 0 holds overall parity. Positions 1..CW_W-1 form a
// Hamming code, with check bits at power-of-two positions and data bits
// filling the remaining positions in ascending order.
//
// Optional feature macro: SECDED_ERR_CNT_EN
//   defined   -> saturating sec_cnt/ded_cnt counters with synchronous cnt_clr
//   undefined -> no counter flops; sec_cnt/ded_cnt are tied to 0 and cnt_clr
//                is ignored
module secded_stream_decoder #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16,
  localparam int P     = (DATA_W <= 4)  ? 3 :
                         (DATA_W <= 11) ? 4 :
                         (DATA_W <= 26) ? 5 :
                         (DATA_W <= 57) ? 6 : 7,
  localparam int CW_W  = DATA_W + P + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sec,
  output logic              out_ded,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  sec_cnt,
  output logic [CNT_W-1:0]  ded_cnt
);

  // Highest valid Hamming position; syndromes above it cannot name a real bit.
  localparam logic [P-1:0] MAX_POS = P'(CW_W - 1);

  // Codeword position that carries data bit idx (skips power-of-two slots).
  function automatic int data_pos(input int idx);
    int cnt;
    data_pos = 0;
    cnt      = 0;
    for (int j = 3; j < CW_W; j++) begin
      if ((j & (j - 1)) != 0) begin
        if (cnt == idx) data_pos = j;
        cnt++;
      end
    end
  endfunction

  // Pipeline state
  logic              s1_valid_q, s1_valid_d;
  logic [P-1:0]      s1_syn_q,   s1_syn_d;
  logic              s1_par_q,   s1_par_d;
  logic [DATA_W-1:0] s1_data_q,  s1_data_d;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              out_sec_q,   out_sec_d;
  logic              out_ded_q,   out_ded_d;

  logic              s1_load;
  logic              s2_load;
  logic              out_xfer;

  logic [P-1:0]      syn_calc;
  logic              par_calc;
  logic [DATA_W-1:0] raw_data;
  logic [DATA_W-1:0] flip_mask;
  logic [DATA_W-1:0] corr_data;
  logic              sec_calc;
  logic              ded_calc;

  // Pull the data bits out of their scattered codeword positions, and build
  // the correction mask: a data bit flips only when the syndrome names its
  // position and the overall parity confirms an odd error count.
  for (genvar g = 0; g < DATA_W; g++) begin : g_data_map
    localparam int           POS   = data_pos(g);
    localparam logic [P-1:0] POS_S = P'(POS);
    assign raw_data[g]  = in_code[POS];
    assign flip_mask[g] = s1_par_q && (s1_syn_q == POS_S);
  end

  // Handshake control: stage 2 advances when its slot is free or being
  // drained; stage 1 advances when empty or when stage 2 takes its word.
  always_comb begin
    s2_load  = !out_valid_q || out_ready;
    s1_load  = !s1_valid_q || s2_load;
    out_xfer = out_valid_q && out_ready;
  end

  assign in_ready = s1_load;

  // Syndrome and overall parity of the incoming codeword.
  always_comb begin
    syn_calc = '0;
    for (int k = 0; k < P; k++) begin
      for (int j = 1; j < CW_W; j++) begin
        if (j[k]) syn_calc[k] = syn_calc[k] ^ in_code[j];
      end
    end
    par_calc = ^in_code;
  end

  // Stage 1 next state: capture syndrome, parity and raw data on accept.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_syn_d   = s1_syn_q;
    s1_par_d   = s1_par_q;
    s1_data_d  = s1_data_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_syn_d  = syn_calc;
        s1_par_d  = par_calc;
        s1_data_d = raw_data;
      end
    end
  end

  // Error classification from stage 1. Parity error with an in-range
  // syndrome (including 0, the parity bit itself) is correctable; anything
  // else with a nonzero syndrome is uncorrectable. The two are exclusive.
  always_comb begin
    corr_data = s1_data_q ^ flip_mask;
    sec_calc  = s1_par_q && (s1_syn_q <= MAX_POS);
    ded_calc  = s1_par_q ? (s1_syn_q > MAX_POS) : (s1_syn_q != '0);
  end

  // Stage 2 next state: output register, held while stalled downstream.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sec_d   = out_sec_q;
    out_ded_d   = out_ded_q;
    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = corr_data;
        out_sec_d  = sec_calc;
        out_ded_d  = ded_calc;
      end
    end
  end

  // Pipeline registers; reset discards every in-flight word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_syn_q    <= '0;
      s1_par_q    <= 1'b0;
      s1_data_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sec_q   <= 1'b0;
      out_ded_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_syn_q    <= s1_syn_d;
      s1_par_q    <= s1_par_d;
      s1_data_q   <= s1_data_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sec_q   <= out_sec_d;
      out_ded_q   <= out_ded_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sec   = out_sec_q;
  assign out_ded   = out_ded_q;

`ifdef SECDED_ERR_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] sec_cnt_q, sec_cnt_d;
  logic [CNT_W-1:0] ded_cnt_q, ded_cnt_d;

  // Counters step only on a completed output transfer; clear has priority.
  always_comb begin
    sec_cnt_d = sec_cnt_q;
    ded_cnt_d = ded_cnt_q;
    if (cnt_clr) begin
      sec_cnt_d = '0;
      ded_cnt_d = '0;
    end else if (out_xfer) begin
      if (out_sec_q && (sec_cnt_q != CNT_MAX)) sec_cnt_d = sec_cnt_q + CNT_ONE;
      if (out_ded_q && (ded_cnt_q != CNT_MAX)) ded_cnt_d = ded_cnt_q + CNT_ONE;
    end
  end

  // Error counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_cnt_q <= '0;
      ded_cnt_q <= '0;
    end else begin
      sec_cnt_q <= sec_cnt_d;
      ded_cnt_q <= ded_cnt_d;
    end
  end

  assign sec_cnt = sec_cnt_q;
  assign ded_cnt = ded_cnt_q;
`else
  // Counters compiled out: outputs constant, clear input has no effect.
  logic unused_cnt_clr;
  logic unused_out_xfer;
  assign unused_cnt_clr  = cnt_clr;
  assign unused_out_xfer = out_xfer;
  assign sec_cnt = '0;
  assign ded_cnt = '0;
`endif

endmodule

// File: tb/tb_secded_stream_decoder.sv
// Directed bench for secded_stream_decoder (DATA_W=8, CW_W=13, CNT_W=4).
// Counter expectations follow SECDED_ERR_CNT_EN: with it undefined the
// counters are expected to stay at 0.
module tb_secded_stream_decoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] in_code;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_sec;
  logic        out_ded;
  logic        cnt_clr;
  logic [3:0]  sec_cnt;
  logic [3:0]  ded_cnt;

`ifdef SECDED_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  int exp_sec = 0;
  int exp_ded = 0;

  logic [7:0]  sdata [100];
  logic        sflip [100];
  int          sent, recv, cyc;
  logic        prev_stall;
  logic [7:0]  prev_data;
  logic        prev_sec;
  logic [7:0]  dval;

  secded_stream_decoder #(.DATA_W(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sec   (out_sec),
    .out_ded   (out_ded),
    .cnt_clr   (cnt_clr),
    .sec_cnt   (sec_cnt),
    .ded_cnt   (ded_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference encoder: data at non-power-of-two positions, then check bits,
  // then overall parity in bit 0.
  function automatic logic [12:0] enc(input logic [7:0] d);
    logic [12:0] c;
    logic        x;
    int          idx;
    c   = '0;
    idx = 0;
    for (int pos = 1; pos < 13; pos++) begin
      if (pos != 1 && pos != 2 && pos != 4 && pos != 8) begin
        c[pos] = d[idx];
        idx++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      x = 1'b0;
      for (int pos = 1; pos < 13; pos++)
        if (pos[k] && pos != (1 << k)) x = x ^ c[pos];
      c[1 << k] = x;
    end
    c[0] = ^c[12:1];
    return c;
  endfunction

  function automatic int sat(input int v);
    return (v >= 15) ? 15 : v + 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One word through an empty pipeline with out_ready high: checks the
  // 2-cycle latency, the decoded result and the counters after the transfer.
  task automatic directed(input string tag, input logic [12:0] code,
                          input logic [7:0] ed, input logic es, input logic edd,
                          input logic clr);
    @(negedge clk);
    check({tag, ".in_ready"}, 32'(in_ready), 1);
    in_valid  = 1'b1;
    in_code   = code;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_code  = '0;
    check({tag, ".lat1_valid"}, 32'(out_valid), 0);
    @(negedge clk);
    check({tag, ".valid"}, 32'(out_valid), 1);
    check({tag, ".data"},  32'(out_data), 32'(ed));
    check({tag, ".sec"},   32'(out_sec), 32'(es));
    check({tag, ".ded"},   32'(out_ded), 32'(edd));
    cnt_clr = clr;
    @(negedge clk);
    cnt_clr = 1'b0;
    if (CNT_EN) begin
      if (clr) begin
        exp_sec = 0;
        exp_ded = 0;
      end else begin
        if (es)  exp_sec = sat(exp_sec);
        if (edd) exp_ded = sat(exp_ded);
      end
    end
    check({tag, ".sec_cnt"}, 32'(sec_cnt), exp_sec);
    check({tag, ".ded_cnt"}, 32'(ded_cnt), exp_ded);
    check({tag, ".drained"}, 32'(out_valid), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_code   = '0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.out_valid", 32'(out_valid), 0);
    check("rst.out_data",  32'(out_data), 0);
    check("rst.out_sec",   32'(out_sec), 0);
    check("rst.out_ded",   32'(out_ded), 0);
    check("rst.sec_cnt",   32'(sec_cnt), 0);
    check("rst.ded_cnt",   32'(ded_cnt), 0);
    check("rst.in_ready",  32'(in_ready), 1);
    rst_n = 1'b1;

    // enc(0xA5) = 0x144E, hand-computed
    directed("clean_a5", 13'h144E, 8'hA5, 1'b0, 1'b0, 1'b0);
    directed("sec_pos3", 13'h144E ^ 13'h0008, 8'hA5, 1'b1, 1'b0, 1'b0);
    // positions 5 (d1) and 9 (d4) flipped: raw data 0x3C ^ 0x12 = 0x2E
    directed("ded_pos5_9", enc(8'h3C) ^ 13'h0220, 8'h2E, 1'b0, 1'b1, 1'b0);
    directed("sec_pos0",   enc(8'h5A) ^ 13'h0001, 8'h5A, 1'b1, 1'b0, 1'b0);
    directed("sec_pos8",   enc(8'hC3) ^ 13'h0100, 8'hC3, 1'b1, 1'b0, 1'b0);
    directed("sec_pos12",  enc(8'h0F) ^ 13'h1000, 8'h0F, 1'b1, 1'b0, 1'b0);
    // positions 1,4,8: syndrome 13 beyond the codeword, parity odd
    directed("ded_syn13",  enc(8'h5A) ^ 13'h0112, 8'h5A, 1'b0, 1'b1, 1'b0);

    // 100 back-to-back words with random downstream stalls
    for (int i = 0; i < 100; i++) begin
      sdata[i] = 8'((i * 37 + 11) & 255);
      sflip[i] = ((i % 3) == 0);
    end
    sent = 0; recv = 0; cyc = 0;
    prev_stall = 1'b0; prev_data = '0; prev_sec = 1'b0;
    while (recv < 100 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(0, 2) != 0);
      in_valid  = (sent < 100);
      if (sent < 100)
        in_code = enc(sdata[sent]) ^ (sflip[sent] ? (13'h1 << (sent % 13)) : 13'h0);
      #1;
      if (prev_stall) begin
        check("stall.valid", 32'(out_valid), 1);
        check("stall.data",  32'(out_data), 32'(prev_data));
        check("stall.sec",   32'(out_sec), 32'(prev_sec));
      end
      if (out_valid && out_ready) begin
        check("stream.data", 32'(out_data), 32'(sdata[recv]));
        check("stream.sec",  32'(out_sec), 32'(sflip[recv]));
        check("stream.ded",  32'(out_ded), 0);
        if (CNT_EN && sflip[recv]) exp_sec = sat(exp_sec);
        recv++;
      end
      if (in_valid && in_ready) sent++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_sec   = out_sec;
    end
    in_valid = 1'b0;
    check("stream.recv_count", recv, 100);
    check("stream.sent_count", sent, 100);
    @(negedge clk);
    check("stream.sec_cnt", 32'(sec_cnt), exp_sec);
    check("stream.ded_cnt", 32'(ded_cnt), exp_ded);
    check("stream.empty",   32'(out_valid), 0);

    // Clear, then 20 single-error words to saturate the 4-bit counter
    directed("clr_clean", enc(8'h11), 8'h11, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      dval = 8'((i * 13) & 255);
      directed("sat_sec", enc(dval) ^ (13'h1 << ((i % 12) + 1)), dval, 1'b1, 1'b0, 1'b0);
    end
    check("sat.sec_cnt", 32'(sec_cnt), CNT_EN ? 15 : 0);
    // clear concurrent with an increment: clear wins
    directed("clr_vs_inc", enc(8'h99) ^ 13'h0040, 8'h99, 1'b1, 1'b0, 1'b1);
    directed("after_clr",  enc(8'h42) ^ 13'h0400, 8'h42, 1'b1, 1'b0, 1'b0);

    // Reset with two words in flight
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code   = enc(8'hE1);
    @(negedge clk);
    in_code   = enc(8'h1E) ^ 13'h0004;
    @(negedge clk);
    in_valid  = 1'b0;
    check("inflight.valid", 32'(out_valid), 1);
    check("inflight.data",  32'(out_data), 32'h0E1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.out_valid", 32'(out_valid), 0);
    check("arst.out_data",  32'(out_data), 0);
    check("arst.sec_cnt",   32'(sec_cnt), 0);
    check("arst.ded_cnt",   32'(ded_cnt), 0);
    exp_sec = 0;
    exp_ded = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("arst.in_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("arst.no_stale", 32'(out_valid), 0);
    end
    directed("post_rst", enc(8'h77), 8'h77, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/secded_stream_decoder.md
SECDED_STREAM_DECODER -- requirements
Module: secded_stream_decoder

Interface
REQ-001 Parameter DATA_W, default 8, data payload width in bits (legal 4..64).
REQ-002 Parameter CNT_W, default 16, error-counter width in bits (legal 4..32).
REQ-003 Derived localparam P = smallest integer with 2^P >= DATA_W+P+1; CW_W = DATA_W+P+1 codeword width.
REQ-004 Clock: clk  input  1  sole clock, all state on rising edge.
REQ-005 Reset: rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream codeword valid.
REQ-007 in_ready  output  1  block accepts codeword this cycle.
REQ-008 in_code  input  CW_W  received codeword.
REQ-009 out_valid  output  1  decoded word valid.
REQ-010 out_ready  input  1  downstream accepts decoded word.
REQ-011 out_data  output  DATA_W  corrected data.
REQ-012 out_sec  output  1  single error detected and corrected.
REQ-013 out_ded  output  1  uncorrectable (double/multi) error detected.
REQ-014 cnt_clr  input  1  synchronous clear of both error counters.
REQ-015 sec_cnt, ded_cnt  output  CNT_W each  saturating error counters.

Function
REQ-016 Codeword layout: bit 0 overall parity; Hamming positions 1..CW_W-1, check bits at power-of-two positions, data bits in remaining positions ascending (data[0] at position 3, data[1] at 5, data[2] at 6, data[3] at 7, data[4] at 9, ...).
REQ-017 Syndrome s (P bits) = XOR of positions whose index has bit k set, for each k; overall parity p = XOR of all CW_W bits.
REQ-018 s=0, p=0: no error; data passed, out_sec=0, out_ded=0.
REQ-019 p=1, s=0: overall parity bit in error; data unchanged, out_sec=1.
REQ-020 p=1, 1<=s<=CW_W-1: flip position s (no data change if s is a check position), out_sec=1.
REQ-021 p=1, s>CW_W-1: out_ded=1, data uncorrected, out_sec=0.
REQ-022 p=0, s!=0: out_ded=1, data uncorrected; out_sec and out_ded never both 1.
REQ-023 Two-stage pipeline: stage 1 registers syndrome, p and raw data; stage 2 registers corrected data and flags; latency exactly 2 cycles from in accept to out_valid with out_ready held high.
REQ-024 Stage 2 loads when !out_valid || out_ready; stage 1 loads when its register is empty or stage 2 loads; in_ready = !s1_valid || stage2_load.
REQ-025 Throughput one word per cycle under continuous in_valid and out_ready; no word dropped or duplicated under any stall pattern.
REQ-026 out_data/out_sec/out_ded held stable while out_valid && !out_ready.
REQ-027 Counters increment only on output transfer (out_valid && out_ready) with corresponding flag set; saturate at 2^CNT_W-1.
REQ-028 cnt_clr same cycle as an increment: clear wins, counter becomes 0.

Reset
REQ-029 rst_n low asynchronously clears both stage valids, out_valid=0, out_data=0, out_sec=0, out_ded=0, sec_cnt=0, ded_cnt=0.
REQ-030 Reset mid-transfer discards all in-flight words; in_ready=1 the first cycle after rst_n deasserts.

Configuration
REQ-031 Macro SECDED_ERR_CNT_EN defined: counters per REQ-027/028 implemented.
REQ-032 Macro undefined: no counter flops; sec_cnt and ded_cnt tied to 0, cnt_clr ignored; datapath unchanged.

Verification (DATA_W=8, CW_W=13, bench reference encoder enc())
REQ-033 enc(0xA5) sent, out_ready=1 -> 2 cycles later out_data=0xA5, out_sec=0, out_ded=0.
REQ-034 enc(0xA5) with position 3 flipped -> out_data=0xA5, out_sec=1, sec_cnt increments 0->1.
REQ-035 enc(0x3C) with positions 5 and 9 flipped -> out_ded=1, out_data=uncorrected raw, ded_cnt 0->1.
REQ-036 100 back-to-back words, out_ready toggled pseudo-randomly -> all 100 emitted in order, unchanged while stalled.
REQ-037 CNT_W=4, 20 single-error words -> sec_cnt saturates at 15; cnt_clr with a concurrent error -> 0.
REQ-038 rst_n pulsed low with 2 words in flight -> out_valid=0 immediately, counters 0, no stale word emitted afterwards.
